bk_ps2_kbd: RTL
===============

BK_PS2_KBD -- requirements
Module: bk_ps2_kbd

Interface
REQ-001 Parameter TIMEOUT, default 20000: m_clock cycles without a PS/2 falling edge before a partial frame is aborted.
REQ-002 Parameter FIFO_DEPTH, default 4: key-event FIFO entries; power of two, minimum 2.
REQ-003 m_clock  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 ps2_clk  in  1  raw PS/2 clock line, asynchronous to m_clock.
REQ-006 ps2_dat  in  1  raw PS/2 data line, asynchronous to m_clock.
REQ-007 kbd_read  in  1  CPU read of the keyboard data register; level, high for one or more cycles per access.
REQ-008 kbd_data  out  8  make scancode at the FIFO head.
REQ-009 kbd_ext  out  1  head entry carried an E0 prefix.
REQ-010 kbd_available  out  1  FIFO not empty.
REQ-011 kbd_ar2  out  1  Alt key (11 or E0 11) currently held.
REQ-012 keydown  out  1  at least one non-modifier key currently held.
REQ-013 stopkey  out  1  F12 (07) currently held.
REQ-014 overflow  out  1  sticky: a make code was dropped because the FIFO was full.
REQ-015 frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-016 ps2_clk and ps2_dat SHALL pass two-flop synchronisers; a falling edge is detected from synchronised samples.
REQ-017 The receiver SHALL sample ps2_dat on each detected falling edge: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
REQ-018 Receiver states: IDLE, DATA, PARITY, STOP. Transitions: IDLE->DATA on start=0; DATA->PARITY after 8 bits; PARITY->STOP; STOP->IDLE.
REQ-019 Start bit of 1 in IDLE SHALL be ignored; no error is reported.
REQ-020 Parity mismatch or stop=0 SHALL discard the byte, pulse frame_err and return to IDLE.
REQ-021 In a non-IDLE state, TIMEOUT cycles without a falling edge SHALL abort to IDLE and pulse frame_err.
REQ-022 A valid byte SHALL reach the decoder one cycle after the stop-bit edge.
REQ-023 Decoder flags: E0 sets pending_ext; F0 sets pending_brk. Any other byte is a key code; both flags clear after it.
REQ-024 Make code (pending_brk=0): push {pending_ext, code} unless the code is 11 or 12/59 (shifts); update held-key state.
REQ-025 Break code: update held-key state; no push.
REQ-026 kbd_ar2 SHALL set on make 11 (either prefix) and clear on its break.
REQ-027 stopkey SHALL set on make 07 and clear on break 07.
REQ-028 keydown SHALL come from a 0-7 counter of held non-modifier keys. Make increments and saturates at 7; break decrements and saturates at 0. Typematic repeats of an already-held key do not increment; one held-key tag per FIFO entry is sufficient.
REQ-029 The FIFO head drives kbd_data/kbd_ext; kbd_available = ~empty.
REQ-030 A rising edge of kbd_read SHALL pop the FIFO one cycle later; a held level pops only once.
REQ-031 Push to a full FIFO SHALL drop the new code and set overflow. overflow clears only on reset.
REQ-032 Simultaneous push and pop SHALL both occur; the count is unchanged, including when full.
REQ-033 Pop when empty SHALL have no effect.
REQ-034 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-035 reset_n low SHALL asynchronously force receiver IDLE, clear both decoder flags, empty the FIFO and zero all outputs. Synchronisers reset to 1 (idle bus).
REQ-036 Reset mid-frame SHALL discard the partial byte; the next valid start bit begins a fresh frame.

Verification
V-1 Reset; send 1C (A make) -> kbd_available=1, kbd_data=1C, kbd_ext=0, keydown=1; pulse kbd_read -> kbd_available=0 within 2 cycles.
V-2 Send F0 1C -> no push, keydown=0. Send E0 75 -> kbd_data=75, kbd_ext=1. Send 11 -> kbd_ar2=1, no push. Send F0 11 -> kbd_ar2=0.
V-3 Send 5 make codes 15,1D,24,2D,2C with no reads -> overflow=1; four reads return 15,1D,24,2D in order; kbd_available=0 after the fourth.
V-4 Send 1C with wrong parity -> frame_err pulse, no push. Send 3 bits then idle TIMEOUT+1 cycles -> frame_err pulse; next 1C received correctly.
V-5 Hold kbd_read high 10 cycles with 2 entries -> exactly one pop. Complete a push on the same cycle a pop occurs with the FIFO full -> count stays 4 and the new entry is at the tail.
V-6 Send 07 -> stopkey=1. Assert reset_n low mid-frame, then release -> all outputs 0. Send F0 07 then 1C -> stopkey=0, kbd_data=1C.

Source files
------------

// File: rtl/bk_ps2_kbd.sv
// PS/2 keyboard receiver and scancode decoder feeding a small key-event FIFO read by the CPU.
// Latency: stop-bit edge to FIFO entry is about 4 cycles; there is no backpressure, and a make code that arrives while the FIFO is full is dropped and flagged in overflow.
module bk_ps2_kbd #(
  parameter int TIMEOUT    = 20000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       m_clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       kbd_read,
  output logic [7:0] kbd_data,
  output logic       kbd_ext,
  output logic       kbd_available,
  output logic       kbd_ar2,
  output logic       keydown,
  output logic       stopkey,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fall, dat_s;
  rx_state_t     rx_state;
  logic [7:0]    rx_shift;
  logic [2:0]    rx_cnt;
  logic          rx_par_ok;
  logic [TW-1:0] rx_timer;
  logic          rx_vld;
  logic [7:0]    rx_byte;

  logic          pend_ext, pend_brk;
  logic          push_vld;
  logic [8:0]    push_dat;
  logic [8:0]    key;
  logic          is_mod;
  logic [FIFO_DEPTH-1:0] held_vld, hit;
  logic [8:0]    held_key [FIFO_DEPTH];
  logic [AW-1:0] free_idx;
  logic          free_any;
  logic [2:0]    held_cnt;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          rd_prev, pop_q;
  logic          full, empty, do_push, do_pop;

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall  = clk_prev & ~clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state  <= IDLE;
      rx_shift  <= '0;
      rx_cnt    <= '0;
      rx_par_ok <= 1'b0;
      rx_timer  <= '0;
      rx_vld    <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      if (fall)
        rx_timer <= '0;
      else if (rx_state != IDLE)
        rx_timer <= rx_timer + 1'b1;

      if (rx_state != IDLE && !fall && rx_timer == TW'(TIMEOUT - 1)) begin
        rx_state  <= IDLE;
        rx_timer  <= '0;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (rx_state)
          IDLE: begin
            // A high start bit is line noise, not a frame
            if (!dat_s) begin
              rx_state <= DATA;
              rx_cnt   <= '0;
            end
          end
          DATA: begin
            rx_shift <= {dat_s, rx_shift[7:1]};
            rx_cnt   <= rx_cnt + 1'b1;
            if (rx_cnt == 3'd7)
              rx_state <= PARITY;
          end
          PARITY: begin
            rx_par_ok <= ^{rx_shift, dat_s};
            rx_state  <= STOP;
          end
          STOP: begin
            rx_state <= IDLE;
            if (dat_s && rx_par_ok) begin
              rx_vld  <= 1'b1;
              rx_byte <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: rx_state <= IDLE;
        endcase
      end
    end
  end

  assign key    = {pend_ext, rx_byte};
  assign is_mod = (rx_byte == 8'h11) || (rx_byte == 8'h12) || (rx_byte == 8'h59);

  always_comb begin
    hit      = '0;
    free_idx = '0;
    free_any = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      hit[i] = held_vld[i] && (held_key[i] == key);
      if (!held_vld[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
      push_vld <= 1'b0;
      push_dat <= '0;
      held_vld <= '0;
      held_cnt <= '0;
      kbd_ar2  <= 1'b0;
      stopkey  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        held_key[i] <= '0;
    end else begin
      push_vld <= 1'b0;
      if (rx_vld) begin
        if (rx_byte == 8'hE0) begin
          pend_ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          pend_brk <= 1'b1;
        end else begin
          pend_ext <= 1'b0;
          pend_brk <= 1'b0;
          if (rx_byte == 8'h11)
            kbd_ar2 <= !pend_brk;
          if (rx_byte == 8'h07)
            stopkey <= !pend_brk;
          if (!is_mod) begin
            if (!pend_brk) begin
              push_vld <= 1'b1;
              push_dat <= key;
              // Typematic repeat of a tagged key leaves the count alone
              if (hit == '0) begin
                if (held_cnt != 3'd7)
                  held_cnt <= held_cnt + 1'b1;
                if (free_any) begin
                  held_vld[free_idx] <= 1'b1;
                  held_key[free_idx] <= key;
                end
              end
            end else begin
              if (held_cnt != 3'd0)
                held_cnt <= held_cnt - 1'b1;
              held_vld <= (held_cnt <= 3'd1) ? '0 : (held_vld & ~hit);
            end
          end
        end
      end
    end
  end

  assign keydown = (held_cnt != 3'd0);

  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop_q & ~empty;
  assign do_push = push_vld & (~full | do_pop);

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_prev  <= 1'b0;
      pop_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_prev <= kbd_read;
      pop_q   <= kbd_read & ~rd_prev;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
      if (push_vld && full && !do_pop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge m_clock) begin
    if (do_push)
      mem[wr_ptr] <= push_dat;
  end

  assign kbd_available      = ~empty;
  assign {kbd_ext, kbd_data} = empty ? 9'd0 : mem[rd_ptr];

endmodule
